// File: rtl/fifo_burst_reader.sv
// Read-side burst master for fifo_flops: pops a programmed number of words and
// re-presents them on a registered valid/ready stream with a starvation timeout.
module fifo_burst_reader #(
    parameter int BITS    = 16,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_burst_len,
    input  logic [BITS-1:0]  i_fifo_dout,
    input  logic             i_fifo_pndng,
    output logic             o_fifo_pop,
    output logic [BITS-1:0]  o_out_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_timed_out,
    output logic [LEN_W-1:0] o_sent_count
);

    localparam int SW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [BITS-1:0]  r_out_data;
    logic             r_out_valid;
    logic             r_timed_out;
    logic [LEN_W-1:0] r_sent_count;
    logic [LEN_W-1:0] r_remaining;
    logic [SW-1:0]    r_starve_cnt;

    logic w_slot_free;
    logic w_accept;
    logic w_pop;
    logic w_starving;
    logic w_starve_limit;

    assign w_slot_free    = !r_out_valid || i_out_ready;
    assign w_accept       = r_out_valid && i_out_ready;
    assign w_pop          = (r_state == S_RUN) && i_fifo_pndng &&
                            (r_remaining != '0) && w_slot_free;
    assign w_starving     = (r_state == S_RUN) && (r_remaining != '0) && !i_fifo_pndng;
    assign w_starve_limit = (r_starve_cnt == SW'(TIMEOUT - 1));

    // The burst only closes once the last word has been handed downstream.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next_state = (i_burst_len != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if ((r_remaining == '0) && w_slot_free) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_timed_out  <= 1'b0;
            r_sent_count <= '0;
            r_remaining  <= '0;
            r_starve_cnt <= '0;
        end else begin
            if (w_pop) begin
                r_out_data  <= i_fifo_dout;
                r_out_valid <= 1'b1;
            end else if (w_accept) begin
                r_out_valid <= 1'b0;
            end

            if ((r_state == S_IDLE) && i_start) begin
                r_sent_count <= '0;
                r_timed_out  <= 1'b0;
                r_remaining  <= i_burst_len;
                r_starve_cnt <= '0;
            end else begin
                if (w_accept) begin
                    r_sent_count <= r_sent_count + LEN_W'(1);
                end
                // Starvation abort zeroes remaining so the normal exit path drains out.
                if (w_pop) begin
                    r_remaining  <= r_remaining - LEN_W'(1);
                    r_starve_cnt <= '0;
                end else if (w_starving) begin
                    if (w_starve_limit) begin
                        r_timed_out  <= 1'b1;
                        r_remaining  <= '0;
                        r_starve_cnt <= '0;
                    end else begin
                        r_starve_cnt <= r_starve_cnt + SW'(1);
                    end
                end
            end
        end
    end

    assign o_fifo_pop   = w_pop;
    assign o_out_data   = r_out_data;
    assign o_out_valid  = r_out_valid;
    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = (r_state == S_DONE);
    assign o_timed_out  = r_timed_out;
    assign o_sent_count = r_sent_count;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a queue-based FIFO environment plus a transaction-level
// model checked every cycle, with literal pins on the directed scenarios.
module tb_fifo_burst_reader;

    localparam int BITS    = 16;
    localparam int LEN_W   = 8;
    localparam int TIMEOUT = 32;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DONE  = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] burstLen = '0;
    logic [BITS-1:0]  fifoDout = '0;
    logic             fifoPndng = 1'b0;
    logic             outReady = 1'b1;
    logic             o_fifo_pop;
    logic [BITS-1:0]  o_out_data;
    logic             o_out_valid;
    logic             o_busy;
    logic             o_done;
    logic             o_timed_out;
    logic [LEN_W-1:0] o_sent_count;

    int checks = 0;
    int errors = 0;

    logic [BITS-1:0] fifoQ[$];
    logic [BITS-1:0] streamQ[$];
    logic [BITS-1:0] heldQ[$];
    logic [BITS-1:0] deliveredLog[$];
    int  streamIdx = 0;
    bit  popSeen = 0;
    int  readyMode = 0;
    int  pushProb = 0;
    int  preloadReq = 0;
    int  preloadAck = 0;
    int  preloadBase = 0;
    int  preloadN = 0;

    int mState = M_IDLE;
    int mRemaining = 0;
    int mStarve = 0;
    int mSent = 0;
    bit mTimedOut = 0;

    fifo_burst_reader #(.BITS(BITS), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (start),
        .i_burst_len  (burstLen),
        .i_fifo_dout  (fifoDout),
        .i_fifo_pndng (fifoPndng),
        .o_fifo_pop   (o_fifo_pop),
        .o_out_data   (o_out_data),
        .o_out_valid  (o_out_valid),
        .i_out_ready  (outReady),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_timed_out  (o_timed_out),
        .o_sent_count (o_sent_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // FIFO environment: pops follow the DUT request seen at the preceding negedge.
    always @(posedge clk) begin
        if (popSeen && rst_n && fifoQ.size() != 0) begin
            void'(fifoQ.pop_front());
        end
        if (preloadReq != preloadAck) begin
            for (int i = 0; i < preloadN; i++) begin
                fifoQ.push_back(BITS'(preloadBase + i));
                streamQ.push_back(BITS'(preloadBase + i));
            end
            preloadAck = preloadReq;
        end
        if (pushProb != 0 && $urandom_range(99) < pushProb) begin
            logic [BITS-1:0] w;
            w = BITS'($urandom_range(16'hffff));
            fifoQ.push_back(w);
            streamQ.push_back(w);
        end
        fifoDout  <= (fifoQ.size() != 0) ? fifoQ[0] : '0;
        fifoPndng <= (fifoQ.size() != 0);
    end

    always @(posedge clk) begin
        #1;
        case (readyMode)
            0:       outReady = 1'b1;
            1:       outReady = !outReady;
            default: outReady = 1'($urandom_range(1));
        endcase
    end

    // Reference model: one held output slot, a word budget and a starvation counter.
    always @(negedge clk) begin
        bit expValid, slotFree, expPop, exitNow;
        if (!rst_n) begin
            if (heldQ.size() != 0) begin
                streamIdx++;
                heldQ.delete();
            end
            mState = M_IDLE; mRemaining = 0; mStarve = 0; mSent = 0; mTimedOut = 0;
            checkOutput("rst_pop",   32'(o_fifo_pop),   0);
            checkOutput("rst_valid", 32'(o_out_valid),  0);
            checkOutput("rst_data",  32'(o_out_data),   0);
            checkOutput("rst_busy",  32'(o_busy),       0);
            checkOutput("rst_done",  32'(o_done),       0);
            checkOutput("rst_tmo",   32'(o_timed_out),  0);
            checkOutput("rst_sent",  32'(o_sent_count), 0);
        end else begin
            expValid = (heldQ.size() != 0);
            slotFree = !expValid || outReady;
            expPop   = (mState == M_RUN) && fifoPndng && (mRemaining != 0) && slotFree;
            checkOutput("pop",   32'(o_fifo_pop),   32'(expPop));
            checkOutput("valid", 32'(o_out_valid),  32'(expValid));
            if (expValid) checkOutput("data", 32'(o_out_data), 32'(heldQ[0]));
            checkOutput("busy",  32'(o_busy),       32'(mState != M_IDLE));
            checkOutput("done",  32'(o_done),       32'(mState == M_DONE));
            checkOutput("tmo",   32'(o_timed_out),  32'(mTimedOut));
            checkOutput("sent",  32'(o_sent_count), 32'(mSent));
            popSeen = o_fifo_pop;

            if (expValid && outReady) begin
                if (streamIdx < streamQ.size()) begin
                    checkOutput("order", 32'(o_out_data), 32'(streamQ[streamIdx]));
                end else begin
                    checkOutput("order_exhausted", 32'(streamIdx), 32'(streamQ.size()));
                end
                streamIdx++;
                deliveredLog.push_back(o_out_data);
                void'(heldQ.pop_front());
                mSent++;
            end

            case (mState)
                M_IDLE: begin
                    if (start) begin
                        mSent = 0; mTimedOut = 0; mStarve = 0;
                        mRemaining = int'(burstLen);
                        mState = (burstLen != 0) ? M_RUN : M_DONE;
                    end
                end
                M_RUN: begin
                    exitNow = (mRemaining == 0) && slotFree;
                    if (expPop) begin
                        heldQ.push_back(fifoDout);
                        mRemaining--;
                        mStarve = 0;
                    end else if (mRemaining != 0 && !fifoPndng) begin
                        mStarve++;
                        if (mStarve == TIMEOUT) begin
                            mTimedOut = 1; mRemaining = 0; mStarve = 0;
                        end
                    end
                    if (exitNow) mState = M_DONE;
                end
                default: mState = M_IDLE;
            endcase
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int base, input int n);
        preloadBase = base;
        preloadN    = n;
        preloadReq++;
        nextCycle();
    endtask

    // Pulses start and counts negedges from the start cycle until done is seen.
    task automatic applyStimulus(input int len, output int cnt);
        start    = 1'b1;
        burstLen = LEN_W'(len);
        nextCycle();
        start = 1'b0;
        cnt   = 1;
        do begin
            @(negedge clk);
            cnt++;
        end while (!o_done && cnt < 2000);
        if (!o_done) checkOutput("done_timeout", 32'(cnt), 0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cnt;
        int mark;
        logic [BITS-1:0] exp3 [6];
        exp3 = '{16'd24, 16'd25, 16'd26, 16'd27, 16'd30, 16'd31};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        nextCycle();

        $display("[TB] scenario 1: full burst of 10");
        preload(0, 10);
        mark = deliveredLog.size();
        applyStimulus(10, cnt);
        checkOutput("t1_latency", 32'(cnt), 13);
        checkOutput("t1_sent", 32'(o_sent_count), 10);
        checkOutput("t1_fifo_empty", 32'(fifoQ.size()), 0);
        checkOutput("t1_count", 32'(deliveredLog.size() - mark), 10);
        for (int i = 0; i < 10 && mark + i < deliveredLog.size(); i++) begin
            checkOutput("t1_word", 32'(deliveredLog[mark + i]), 32'(i));
        end
        nextCycle();

        $display("[TB] scenario 2: partial drain");
        preload(20, 8);
        applyStimulus(4, cnt);
        checkOutput("t2_left", 32'(fifoQ.size()), 4);
        checkOutput("t2_tmo", 32'(o_timed_out), 0);
        checkOutput("t2_sent", 32'(o_sent_count), 4);
        nextCycle();
        checkOutput("t2_pndng", 32'(fifoPndng), 1);

        $display("[TB] scenario 3: toggled backpressure");
        preload(30, 2);
        readyMode = 1;
        mark = deliveredLog.size();
        applyStimulus(6, cnt);
        checkOutput("t3_sent", 32'(o_sent_count), 6);
        checkOutput("t3_count", 32'(deliveredLog.size() - mark), 6);
        for (int i = 0; i < 6 && mark + i < deliveredLog.size(); i++) begin
            checkOutput("t3_word", 32'(deliveredLog[mark + i]), 32'(exp3[i]));
        end
        readyMode = 0;
        nextCycle();

        $display("[TB] scenario 4: starvation timeout");
        preload(40, 3);
        applyStimulus(5, cnt);
        checkOutput("t4_latency", 32'(cnt), TIMEOUT + 6);
        checkOutput("t4_tmo", 32'(o_timed_out), 1);
        checkOutput("t4_sent", 32'(o_sent_count), 3);
        nextCycle();

        $display("[TB] scenario 5: zero-length burst");
        applyStimulus(0, cnt);
        checkOutput("t5_latency", 32'(cnt), 2);
        checkOutput("t5_sent", 32'(o_sent_count), 0);
        checkOutput("t5_tmo", 32'(o_timed_out), 0);
        nextCycle();

        $display("[TB] scenario 6: reset mid-burst");
        preload(50, 6);
        start    = 1'b1;
        burstLen = LEN_W'(6);
        nextCycle();
        start = 1'b0;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (o_sent_count != 2 && cnt < 100);
        checkOutput("t6_reach2", 32'(o_sent_count), 2);
        nextCycle();
        rst_n = 1'b0;
        #1;
        checkOutput("t6_valid_clr", 32'(o_out_valid), 0);
        checkOutput("t6_busy_clr", 32'(o_busy), 0);
        checkOutput("t6_sent_clr", 32'(o_sent_count), 0);
        checkOutput("t6_pop_clr", 32'(o_fifo_pop), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        nextCycle();
        mark = deliveredLog.size();
        applyStimulus(2, cnt);
        checkOutput("t6_count", 32'(deliveredLog.size() - mark), 2);
        if (deliveredLog.size() >= mark + 2) begin
            checkOutput("t6_word0", 32'(deliveredLog[mark]), 54);
            checkOutput("t6_word1", 32'(deliveredLog[mark + 1]), 55);
        end
        nextCycle();

        $display("[TB] random phase");
        readyMode = 2;
        pushProb  = 60;
        for (int b = 0; b < 25; b++) begin
            applyStimulus($urandom_range(12), cnt);
            nextCycle();
            repeat ($urandom_range(3)) nextCycle();
        end
        pushProb  = 0;
        readyMode = 0;
        repeat (3) nextCycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
